// File: rtl/plot_pkg.sv
// Shared types and constants for the plot_arbiter rectangle-plot engine.
package plot_pkg;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // LSB of channel ch inside a packed per-channel field of width w.
  function automatic int field_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/rect_sweeper.sv
// Row-major rectangle walker: column/row counters plus the coordinate adders.
// start clears the counters, step advances them, last flags the final pixel.
module rect_sweeper
  import plot_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int SIZE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [X_W-1:0]    base_x,
  input  logic [Y_W-1:0]    base_y,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  output logic [X_W:0]      sum_x,
  output logic [Y_W:0]      sum_y,
  output logic              last
);

  logic [SIZE_W-1:0] col_p0;
  logic [SIZE_W-1:0] row_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (start) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (step) begin
      if (col_p0 == w) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == h) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  assign last = (col_p0 == w) && (row_p0 == h);

  // One extra bit keeps the untruncated sum visible for screen clipping.
  assign sum_x = {1'b0, base_x} + (X_W+1)'(col_p0);
  assign sum_y = {1'b0, base_y} + (Y_W+1)'(row_p0);

endmodule

// File: rtl/plot_arbiter.sv
// N-channel rectangle-plot arbiter driving registered VGA x/y/colour/plot.
// Define PLOT_CLIP_EN to suppress plot for pixels outside SCREEN_W x SCREEN_H.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int N_CH     = 5,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int SIZE_W   = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ARB_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*X_W-1:0]      req_x,
  input  logic [N_CH*Y_W-1:0]      req_y,
  input  logic [N_CH*SIZE_W-1:0]   req_w,
  input  logic [N_CH*SIZE_W-1:0]   req_h,
  input  logic [N_CH*COL_W-1:0]    req_colour,
  output logic [N_CH-1:0]          ack,
  output logic [N_CH-1:0]          done,
  output logic                     busy,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COL_W-1:0]         colour,
  output logic                     plot
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, win, cur_ch;
  logic               grant, start, last, vld_p1, pix_on;
  int                 rr_idx;
  logic [X_W-1:0]     lat_x;
  logic [Y_W-1:0]     lat_y;
  logic [SIZE_W-1:0]  lat_w, lat_h;
  logic [COL_W-1:0]   lat_col;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;

  function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy);
    return (int'(sx) < SCREEN_W) && (int'(sy) < SCREEN_H);
  endfunction

  always_comb begin
    grant  = 1'b0;
    win    = '0;
    rr_idx = 0;
    if (ARB_MODE == ARB_RR) begin
      for (int k = 1; k <= N_CH; k++) begin
        rr_idx = (int'(ptr) + k) % N_CH;
        if (!grant && req[rr_idx]) begin
          grant = 1'b1;
          win   = IDX_W'(rr_idx);
        end
      end
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (req[k]) begin
          grant = 1'b1;
          win   = IDX_W'(k);
        end
      end
    end
  end

  assign start = (state == IDLE) && grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (grant) state_d = SWEEP;
      SWEEP: if (last)  state_d = IDLE;
    endcase
  end

  // Command fields are captured only in the arbitration cycle.
  always_ff @(posedge clock) begin
    if (start) begin
      lat_x   <= req_x[field_lsb(int'(win), X_W) +: X_W];
      lat_y   <= req_y[field_lsb(int'(win), Y_W) +: Y_W];
      lat_w   <= req_w[field_lsb(int'(win), SIZE_W) +: SIZE_W];
      lat_h   <= req_h[field_lsb(int'(win), SIZE_W) +: SIZE_W];
      lat_col <= req_colour[field_lsb(int'(win), COL_W) +: COL_W];
    end
  end

  rect_sweeper #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .SIZE_W (SIZE_W)
  ) u_sweeper (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .step   (state == SWEEP),
    .base_x (lat_x),
    .base_y (lat_y),
    .w      (lat_w),
    .h      (lat_h),
    .sum_x  (sum_x),
    .sum_y  (sum_y),
    .last   (last)
  );

`ifdef PLOT_CLIP_EN
  assign pix_on = on_screen(sum_x, sum_y);
`else
  logic unused_clip;
  assign pix_on      = 1'b1;
  assign unused_clip = ^{sum_x[X_W], sum_y[Y_W], on_screen(sum_x, sum_y)};
`endif

  // Output stage: one registered pixel per SWEEP cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack    <= '0;
      done   <= '0;
      plot   <= 1'b0;
      vld_p1 <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      cur_ch <= '0;
      ptr    <= IDX_W'(N_CH - 1);
    end else begin
      ack    <= '0;
      done   <= '0;
      plot   <= 1'b0;
      vld_p1 <= 1'b0;
      if (start) begin
        ack[win] <= 1'b1;
        cur_ch   <= win;
        ptr      <= win;
      end
      if (state == SWEEP) begin
        x      <= sum_x[X_W-1:0];
        y      <= sum_y[Y_W-1:0];
        colour <= lat_col;
        plot   <= pix_on;
        vld_p1 <= 1'b1;
        if (last) done[cur_ch] <= 1'b1;
      end
    end
  end

  assign busy = (state == SWEEP) || vld_p1;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: a fixed-priority and a round-robin instance
// are driven side by side and checked against a transaction-level model.
module tb_plot_arbiter;

  localparam int N_CH     = 5;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;
  localparam int SIZE_W   = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef struct {
    int                  cyc;
    logic [N_CH-1:0]     ack;
    logic [N_CH-1:0]     done;
    logic                plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COL_W-1:0]    col;
    bit                  pix;
  } rec_t;

  logic clock;
  logic reset;
  logic [N_CH-1:0]        req     [2];
  logic [N_CH*X_W-1:0]    req_x   [2];
  logic [N_CH*Y_W-1:0]    req_y   [2];
  logic [N_CH*SIZE_W-1:0] req_w   [2];
  logic [N_CH*SIZE_W-1:0] req_h   [2];
  logic [N_CH*COL_W-1:0]  req_col [2];
  logic [N_CH-1:0]        ack_o   [2];
  logic [N_CH-1:0]        done_o  [2];
  logic                   busy_o  [2];
  logic                   plot_o  [2];
  logic [X_W-1:0]         x_o     [2];
  logic [Y_W-1:0]         y_o     [2];
  logic [COL_W-1:0]       col_o   [2];

  int cyc   = 0;
  int nvec  = 0;
  int nerr  = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  plot_arbiter #(
    .N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .SIZE_W(SIZE_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ARB_MODE(0)
  ) u_fixed (
    .clock(clock), .reset(reset), .req(req[0]), .req_x(req_x[0]), .req_y(req_y[0]),
    .req_w(req_w[0]), .req_h(req_h[0]), .req_colour(req_col[0]),
    .ack(ack_o[0]), .done(done_o[0]), .busy(busy_o[0]),
    .x(x_o[0]), .y(y_o[0]), .colour(col_o[0]), .plot(plot_o[0])
  );

  plot_arbiter #(
    .N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .SIZE_W(SIZE_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ARB_MODE(1)
  ) u_rr (
    .clock(clock), .reset(reset), .req(req[1]), .req_x(req_x[1]), .req_y(req_y[1]),
    .req_w(req_w[1]), .req_h(req_h[1]), .req_colour(req_col[1]),
    .ack(ack_o[1]), .done(done_o[1]), .busy(busy_o[1]),
    .x(x_o[1]), .y(y_o[1]), .colour(col_o[1]), .plot(plot_o[1])
  );

  task automatic chk(input string nm, input int m, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, m, cyc, got, want);
    end
  endtask

  // Winner by the arbitration rule: mode 0 lowest index, mode 1 first after ptr.
  function automatic int pick(input logic [N_CH-1:0] r, input int mode, input int ptr);
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (mode == 1) ? (ptr + 1 + k) % N_CH : k;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  for (genvar m = 0; m < 2; m++) begin : g_sb
    rec_t q[$];
    int   bfrom = 1;
    int   bto   = 0;

    // Reference model: on each free arbitration cycle expand the winning command
    // into the list of visible output cycles it must produce.
    initial begin : model
      int   mc, free_at, ptr, win, bx, by, bw, bh, bc, k, sx, sy;
      logic vis, lst;
      rec_t e;
      mc = 0; free_at = 0; ptr = N_CH - 1;
      forever begin
        @(posedge clock);
        mc++;
        if (reset) begin
          ptr = N_CH - 1; free_at = 0; bfrom = 1; bto = 0;
        end else if (mc >= free_at && req[m] != '0) begin
          win = pick(req[m], m, ptr);
          if (m == 1) ptr = win;
          bx = int'(req_x[m][win*X_W +: X_W]);
          by = int'(req_y[m][win*Y_W +: Y_W]);
          bw = int'(req_w[m][win*SIZE_W +: SIZE_W]);
          bh = int'(req_h[m][win*SIZE_W +: SIZE_W]);
          bc = int'(req_col[m][win*COL_W +: COL_W]);
          e = '{cyc: mc, ack: N_CH'(1) << win, done: '0, plot: 1'b0, x: '0, y: '0, col: '0, pix: 1'b0};
          q.push_back(e);
          k = 0;
          for (int r = 0; r <= bh; r++) begin
            for (int c = 0; c <= bw; c++) begin
              k++;
              sx  = bx + c;
              sy  = by + r;
              lst = (r == bh) && (c == bw);
              vis = 1'b1;
`ifdef PLOT_CLIP_EN
              vis = (sx < SCREEN_W) && (sy < SCREEN_H);
`endif
              if (vis || lst) begin
                e = '{cyc: mc + k, ack: '0, done: lst ? (N_CH'(1) << win) : '0, plot: vis,
                      x: X_W'(sx), y: Y_W'(sy), col: COL_W'(bc), pix: 1'b1};
                q.push_back(e);
              end
            end
          end
          bfrom   = mc;
          bto     = mc + k;
          free_at = mc + k + 1;
        end
      end
    end

    initial begin : monitor
      rec_t e;
      forever begin
        @(negedge clock);
        if (reset) begin
          q.delete();
          chk("reset_state", m, {ack_o[m], done_o[m], plot_o[m], busy_o[m], x_o[m], y_o[m], col_o[m]}, 64'd0);
        end else begin
          chk("busy", m, busy_o[m], (cyc >= bfrom && cyc <= bto));
          if (ack_o[m] != '0 || done_o[m] != '0 || plot_o[m]) begin
            if (q.size() == 0) begin
              chk("unexpected_out", m, {ack_o[m], done_o[m], plot_o[m]}, 64'd0);
            end else begin
              e = q.pop_front();
              chk("out_cycle", m, cyc, e.cyc);
              if (e.pix)
                chk("pixel", m, {ack_o[m], done_o[m], plot_o[m], x_o[m], y_o[m], col_o[m]},
                    {e.ack, e.done, e.plot, e.x, e.y, e.col});
              else
                chk("ack", m, {ack_o[m], done_o[m], plot_o[m]}, {e.ack, e.done, e.plot});
            end
          end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("missing_out", m, {ack_o[m], done_o[m], plot_o[m]}, {e.ack, e.done, e.plot});
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    for (int m = 0; m < 2; m++) req[m] = req[m] & ~ack_o[m];
  endtask

  task automatic set_fields(input int m, input int i, input int px, input int py,
                            input int pw, input int ph, input int pc);
    req_x[m][i*X_W +: X_W]        = X_W'(px);
    req_y[m][i*Y_W +: Y_W]        = Y_W'(py);
    req_w[m][i*SIZE_W +: SIZE_W]  = SIZE_W'(pw);
    req_h[m][i*SIZE_W +: SIZE_W]  = SIZE_W'(ph);
    req_col[m][i*COL_W +: COL_W]  = COL_W'(pc);
  endtask

  task automatic post(input int m, input int i, input int px, input int py,
                      input int pw, input int ph, input int pc);
    set_fields(m, i, px, py, pw, ph, pc);
    req[m][i] = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req[0] | req[1]) != '0 || busy_o[0] || busy_o[1]) begin
      tick();
      n++;
      if (n > 4000) begin
        chk("drain_timeout", 0, n, 0);
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic wait_ack(input int m, input int i);
    int n;
    n = 0;
    while (!ack_o[m][i]) begin
      tick();
      n++;
      if (n > 200) begin
        chk("ack_timeout", m, n, 0);
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; req_x[m] = '0; req_y[m] = '0;
      req_w[m] = '0; req_h[m] = '0; req_col[m] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;

    // Two simultaneous requests, ch1 2x2 then ch3 1x1
    for (int m = 0; m < 2; m++) begin
      post(m, 1, 10, 20, 1, 1, 2);
      post(m, 3, 30, 40, 0, 0, 7);
    end
    drain();

    // Every channel requesting continuously
    for (int c = 0; c < 40; c++) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < N_CH; i++)
          if (!req[m][i]) post(m, i, 5 * i, 10 + c, 0, 0, i);
      tick();
    end
    drain();

    // 1x1 at the origin, then a strip crossing the right screen edge
    for (int m = 0; m < 2; m++) post(m, 0, 0, 0, 0, 0, 5);
    drain();
    for (int m = 0; m < 2; m++) post(m, 2, 158, 5, 3, 0, 1);
    drain();

    // Reset in the middle of a 4x4 fill, with ch3 and ch0 waiting
    for (int m = 0; m < 2; m++) post(m, 4, 20, 30, 3, 3, 6);
    wait_ack(0, 4);
    repeat (3) tick();
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      post(m, 3, 70, 80, 1, 0, 3);
      post(m, 0, 90, 100, 0, 1, 4);
    end
    repeat (2) tick();
    reset = 1'b0;
    drain();

    // One-cycle req[2] pulse while ch0 sweeps
    for (int m = 0; m < 2; m++) post(m, 0, 50, 60, 3, 1, 4);
    wait_ack(0, 0);
    for (int m = 0; m < 2; m++) post(m, 2, 1, 2, 0, 0, 6);
    tick();
    for (int m = 0; m < 2; m++) req[m][2] = 1'b0;
    drain();

    // Random traffic: posts, withdrawals and field changes on pending requests
    for (int it = 0; it < 3000; it++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N_CH; i++) begin
          int r;
          r = int'($urandom_range(0, 99));
          if (!req[m][i] && r < 6)
            post(m, i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
          else if (req[m][i] && r == 99)
            req[m][i] = 1'b0;
          else if (req[m][i] && r == 98)
            set_fields(m, i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
      end
    end
    drain();
    repeat (100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
